regbank_wb_arbiter: RTL and testbench

Shares the single write port of the register bank (RD/WB/WE) among N writeback sources. The default sources are 0 = ALU, 1 = memory load and 2 = link write from branch-and-link. Each source has a one-entry holding buffer with a valid/ready handshake. A round-robin arbiter drains the buffers into a registered write port. A pending-write scoreboard tells decode whether the RS/RX/RK source registers still have writes in flight.

---
 rtl/regbank_wb_arbiter.sv | 166 ++++++++++++++++
 tb/tb_regbank_wb_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_wb_arbiter.sv
// Writeback arbiter for the register bank's single write port: per-source holding
// buffers, round-robin drain into a registered RD/WB/WE stage, and a pending-write scoreboard.
module regbank_wb_arbiter #(
  parameter int bus     = 32,
  parameter int dir     = 4,
  parameter int reg_num = 2**dir,
  parameter int N       = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         wr_valid,
  output logic [N-1:0]         wr_ready,
  input  logic [N*dir-1:0]     wr_rd,
  input  logic [N*bus-1:0]     wr_data,
  input  logic [dir-1:0]       RS,
  input  logic [dir-1:0]       RX,
  input  logic [dir-1:0]       RK,
  output logic                 WE,
  output logic [dir-1:0]       RD,
  output logic [bus-1:0]       WB,
  output logic                 rs_busy,
  output logic                 rx_busy,
  output logic                 rk_busy,
  output logic                 stall,
  output logic [reg_num-1:0]   pend
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   hold_v_r;
  logic [dir-1:0] hold_rd_r [N];
  logic [bus-1:0] hold_d_r  [N];
  logic [PW-1:0]  ptr_r;

  logic [PW:0]    dist_s [N];
  logic [N-1:0]   grant_s;
  logic           gany_s;
  logic [dir-1:0] g_rd_s;
  logic [bus-1:0] g_d_s;
  logic [PW-1:0]  nptr_s;
  logic [N-1:0]   waw_s;
  logic [N-1:0]   ready_s;
  logic [N-1:0]   accept_s;

  // Round-robin grant: distance of each source from ptr, lowest distance among valid holders wins
  always_comb begin
    grant_s = '0;
    gany_s  = 1'b0;
    g_rd_s  = '0;
    g_d_s   = '0;
    nptr_s  = ptr_r;
    for (int i = 0; i < N; i++) begin
      if ((PW+1)'(i) >= {1'b0, ptr_r}) begin
        dist_s[i] = (PW+1)'(i) - {1'b0, ptr_r};
      end else begin
        dist_s[i] = (PW+1)'(i + N) - {1'b0, ptr_r};
      end
    end
    for (int i = 0; i < N; i++) begin
      grant_s[i] = hold_v_r[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && hold_v_r[j] && (dist_s[j] < dist_s[i])) begin
          grant_s[i] = 1'b0;
        end else begin
          grant_s[i] = grant_s[i];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (grant_s[i]) begin
        gany_s = 1'b1;
        g_rd_s = hold_rd_r[i];
        g_d_s  = hold_d_r[i];
        nptr_s = (i == N - 1) ? PW'(0) : PW'(i + 1);
      end else begin
        gany_s = gany_s;
      end
    end
  end

  // Ready with write-after-write serialisation; lower source index wins same-cycle ties
  always_comb begin
    waw_s   = '0;
    ready_s = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j != i && hold_v_r[j] && !grant_s[j] &&
            (hold_rd_r[j] == wr_rd[i*dir +: dir])) begin
          waw_s[i] = 1'b1;
        end else begin
          waw_s[i] = waw_s[i];
        end
      end
      for (int j = 0; j < i; j++) begin
        if (wr_valid[j] && ready_s[j] && (wr_rd[j*dir +: dir] == wr_rd[i*dir +: dir])) begin
          waw_s[i] = 1'b1;
        end else begin
          waw_s[i] = waw_s[i];
        end
      end
      ready_s[i] = (!hold_v_r[i] || grant_s[i]) && !waw_s[i];
    end
  end

  assign wr_ready = ready_s;
  assign accept_s = wr_valid & ready_s;

  // Holding buffers, round-robin pointer and the registered write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_v_r <= '0;
      for (int i = 0; i < N; i++) begin
        hold_rd_r[i] <= '0;
        hold_d_r[i]  <= '0;
      end
      ptr_r <= '0;
      WE    <= 1'b0;
      RD    <= '0;
      WB    <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        // A same-edge refill takes priority over the clear from its own grant
        if (accept_s[i]) begin
          hold_v_r[i]  <= 1'b1;
          hold_rd_r[i] <= wr_rd[i*dir +: dir];
          hold_d_r[i]  <= wr_data[i*bus +: bus];
        end else if (grant_s[i]) begin
          hold_v_r[i] <= 1'b0;
        end else begin
          hold_v_r[i] <= hold_v_r[i];
        end
      end
      if (gany_s) begin
        WE    <= 1'b1;
        RD    <= g_rd_s;
        WB    <= g_d_s;
        ptr_r <= nptr_s;
      end else begin
        WE <= 1'b0;
      end
    end
  end

  // Scoreboard: held entries plus the output stage, which writes at the end of its cycle
  always_comb begin
    pend = '0;
    for (int i = 0; i < N; i++) begin
      if (hold_v_r[i]) begin
        pend[hold_rd_r[i]] = 1'b1;
      end else begin
        pend = pend;
      end
    end
    if (WE) begin
      pend[RD] = 1'b1;
    end else begin
      pend = pend;
    end
  end

  assign rs_busy = pend[RS];
  assign rx_busy = pend[RX];
  assign rk_busy = pend[RK];
  assign stall   = rs_busy | rx_busy | rk_busy;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Randomised and directed bench for regbank_wb_arbiter against a cycle-level behavioural model.
module tb_regbank_wb_arbiter;

  localparam int BUS = 32;
  localparam int DIR = 4;
  localparam int RN  = 16;
  localparam int N   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [N-1:0]       wr_valid;
  logic [N-1:0]       wr_ready;
  logic [N*DIR-1:0]   wr_rd;
  logic [N*BUS-1:0]   wr_data;
  logic [DIR-1:0]     RS, RX, RK;
  logic               WE;
  logic [DIR-1:0]     RD;
  logic [BUS-1:0]     WB;
  logic               rs_busy, rx_busy, rk_busy, stall;
  logic [RN-1:0]      pend;

  regbank_wb_arbiter #(.bus(BUS), .dir(DIR), .reg_num(RN), .N(N)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_rd(wr_rd), .wr_data(wr_data), .RS(RS), .RX(RX), .RK(RK),
    .WE(WE), .RD(RD), .WB(WB), .rs_busy(rs_busy), .rx_busy(rx_busy),
    .rk_busy(rk_busy), .stall(stall), .pend(pend)
  );

  int vectors = 0;
  int miscompares = 0;

  // model state
  bit             mv  [N];
  logic [DIR-1:0] mrd [N];
  logic [BUS-1:0] md  [N];
  int             mptr;
  bit             mwe;
  logic [DIR-1:0] mRD;
  logic [BUS-1:0] mwb;
  // model combinational view for the current cycle
  int             g;
  logic [N-1:0]   eready;
  logic [RN-1:0]  epend;
  logic [BUS-1:0] wq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0; mrd[i] = '0; md[i] = '0;
    end
    mptr = 0; mwe = 1'b0; mRD = '0; mwb = '0;
  endtask

  task automatic model_comb();
    g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (mptr + k) % N;
      if (g < 0 && mv[idx]) g = idx;
    end
    eready = '0;
    for (int i = 0; i < N; i++) begin
      logic [DIR-1:0] ri;
      bit conflict;
      ri = wr_rd[i*DIR +: DIR];
      conflict = 1'b0;
      for (int j = 0; j < N; j++)
        if (j != i && mv[j] && mrd[j] == ri && g != j) conflict = 1'b1;
      for (int j = 0; j < i; j++)
        if (wr_valid[j] && wr_rd[j*DIR +: DIR] == ri && eready[j]) conflict = 1'b1;
      eready[i] = (!mv[i] || g == i) && !conflict;
    end
    epend = '0;
    for (int i = 0; i < N; i++) if (mv[i]) epend[mrd[i]] = 1'b1;
    if (mwe) epend[mRD] = 1'b1;
  endtask

  task automatic model_update();
    logic [N-1:0] acc;
    acc = wr_valid & eready;
    if (g >= 0) begin
      mwe = 1'b1; mRD = mrd[g]; mwb = md[g]; mv[g] = 1'b0;
      mptr = (g + 1) % N;
    end else begin
      mwe = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        mv[i] = 1'b1; mrd[i] = wr_rd[i*DIR +: DIR]; md[i] = wr_data[i*BUS +: BUS];
      end
    end
  endtask

  task automatic compare();
    check("wr_ready", 64'(wr_ready), 64'(eready));
    check("WE", 64'(WE), 64'(mwe));
    check("RD", 64'(RD), 64'(mRD));
    check("WB", 64'(WB), 64'(mwb));
    check("pend", 64'(pend), 64'(epend));
    check("rs_busy", 64'(rs_busy), 64'(epend[RS]));
    check("rx_busy", 64'(rx_busy), 64'(epend[RX]));
    check("rk_busy", 64'(rk_busy), 64'(epend[RK]));
    check("stall", 64'(stall), 64'(epend[RS] | epend[RX] | epend[RK]));
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N*DIR-1:0] r,
                       input logic [N*BUS-1:0] d, input logic [DIR-1:0] s,
                       input logic [DIR-1:0] x, input logic [DIR-1:0] k);
    @(negedge clk);
    wr_valid = v; wr_rd = r; wr_data = d; RS = s; RX = x; RK = k;
    #1;
    model_comb();
    compare();
    if (WE) wq.push_back(WB);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive('0, '0, '0, '0, '0, '0);
      advance();
    end
  endtask

  initial begin
    int ia, ib;
    logic r1;
    rst = 1'b0; wr_valid = '0; wr_rd = '0; wr_data = '0; RS = '0; RX = '0; RK = '0;
    model_reset();
    #1;
    model_comb();
    compare();
    check("reset_we", 64'(WE), 64'd0);
    check("reset_pend", 64'(pend), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // single write: accept, grant next edge, WE the cycle after
    drive(3'b001, {4'd0, 4'd0, 4'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 4'd0, 4'd0, 4'd0);
    check("single_ready", 64'(wr_ready[0]), 64'd1);
    advance();
    drive('0, '0, '0, 4'd0, 4'd0, 4'd0);
    check("single_we_lat1", 64'(WE), 64'd0);
    check("single_pend_held", 64'(pend[5]), 64'd1);
    advance();
    drive('0, '0, '0, 4'd0, 4'd0, 4'd0);
    check("single_we", 64'(WE), 64'd1);
    check("single_rd", 64'(RD), 64'd5);
    check("single_wb", 64'(WB), 64'hDEADBEEF);
    check("single_pend_out", 64'(pend[5]), 64'd1);
    advance();
    drive('0, '0, '0, 4'd0, 4'd0, 4'd0);
    check("single_we_drop", 64'(WE), 64'd0);
    check("single_pend_clear", 64'(pend[5]), 64'd0);
    advance();
    idle(2);

    // WAW tie on rd 7: ALU first, MEM waits for the ALU grant
    drive(3'b011, {4'd0, 4'd7, 4'd7}, {32'h0, 32'h22, 32'h11}, 4'd0, 4'd0, 4'd0);
    check("waw_alu_ready", 64'(wr_ready[0]), 64'd1);
    check("waw_mem_blocked", 64'(wr_ready[1]), 64'd0);
    advance();
    drive(3'b010, {4'd0, 4'd7, 4'd0}, {32'h0, 32'h22, 32'h0}, 4'd0, 4'd0, 4'd0);
    check("waw_mem_on_grant", 64'(wr_ready[1]), 64'd1);
    advance();
    drive('0, '0, '0, 4'd0, 4'd0, 4'd0);
    check("waw_first_wb", 64'(WB), 64'h11);
    check("waw_first_rd", 64'(RD), 64'd7);
    advance();
    drive('0, '0, '0, 4'd0, 4'd0, 4'd0);
    check("waw_second_we", 64'(WE), 64'd1);
    check("waw_second_wb", 64'(WB), 64'h22);
    advance();
    idle(2);

    // decode hazard on rd 9
    drive(3'b100, {4'd9, 4'd0, 4'd0}, {32'h99, 32'h0, 32'h0}, 4'd9, 4'd3, 4'd9);
    advance();
    drive('0, '0, '0, 4'd9, 4'd3, 4'd9);
    check("haz_rs", 64'(rs_busy), 64'd1);
    check("haz_rx", 64'(rx_busy), 64'd0);
    check("haz_rk", 64'(rk_busy), 64'd1);
    check("haz_stall", 64'(stall), 64'd1);
    advance();
    drive('0, '0, '0, 4'd9, 4'd3, 4'd9);
    check("haz_we_rd", 64'(RD), 64'd9);
    check("haz_stall_out", 64'(stall), 64'd1);
    advance();
    drive('0, '0, '0, 4'd9, 4'd3, 4'd9);
    check("haz_clear", 64'(stall), 64'd0);
    advance();
    idle(2);

    // reset mid-operation with all buffers full
    drive(3'b111, {4'd3, 4'd2, 4'd1}, {32'h3, 32'h2, 32'h1}, 4'd0, 4'd0, 4'd0);
    advance();
    drive(3'b111, {4'd3, 4'd2, 4'd1}, {32'h3, 32'h2, 32'h1}, 4'd0, 4'd0, 4'd0);
    advance();
    @(negedge clk);
    wr_valid = '0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("rst_we", 64'(WE), 64'd0);
    check("rst_pend", 64'(pend), 64'd0);
    check("rst_ready", 64'(wr_ready), 64'(3'b111));
    @(posedge clk);
    @(negedge clk);
    check("rst_we_held", 64'(WE), 64'd0);
    rst = 1'b1;
    idle(4);

    // round robin from a fresh pointer: RD 1,2,3,... and one ready per cycle
    for (int k = 0; k < 10; k++) begin
      drive(3'b111, {4'd3, 4'd2, 4'd1}, {32'h300 + 32'(k), 32'h200 + 32'(k), 32'h100 + 32'(k)},
            4'd0, 4'd0, 4'd0);
      if (k >= 1) check("rr_one_ready", 64'($countones(wr_ready)), 64'd1);
      if (k >= 2) begin
        check("rr_we", 64'(WE), 64'd1);
        check("rr_rd", 64'(RD), 64'((k - 2) % 3 + 1));
      end
      advance();
    end
    idle(5);

    // backpressure: MEM holds rd 4 ungranted; a new rd 4 request waits for that grant
    wq.delete();
    drive(3'b111, {4'd11, 4'd4, 4'd10}, {32'h3, 32'hAAAA, 32'h1}, 4'd0, 4'd0, 4'd0);
    advance();
    r1 = 1'b0;
    for (int c = 0; c < 8 && !r1; c++) begin
      drive(3'b010, {4'd0, 4'd4, 4'd0}, {32'h0, 32'hBBBB, 32'h0}, 4'd0, 4'd0, 4'd0);
      r1 = wr_ready[1];
      advance();
    end
    check("bp_accepted", 64'(r1), 64'd1);
    idle(6);
    ia = -1; ib = -1;
    foreach (wq[i]) begin
      if (wq[i] == 32'hAAAA && ia < 0) ia = i;
      if (wq[i] == 32'hBBBB && ib < 0) ib = i;
    end
    check("bp_old_written", 64'(ia >= 0), 64'd1);
    check("bp_order", 64'(ia >= 0 && ib > ia), 64'd1);

    // randomized traffic with deliberately colliding destinations
    for (int c = 0; c < 400; c++) begin
      logic [N*DIR-1:0] r;
      logic [N*BUS-1:0] d;
      for (int i = 0; i < N; i++) begin
        r[i*DIR +: DIR] = ($urandom_range(0, 3) == 0) ? DIR'($urandom_range(0, 15))
                                                       : DIR'($urandom_range(0, 3));
        d[i*BUS +: BUS] = $urandom;
      end
      drive(N'($urandom), r, d, DIR'($urandom_range(0, 15)), DIR'($urandom_range(0, 15)),
            DIR'($urandom_range(0, 15)));
      advance();
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
